// File: rtl/obj_scheduler.sv
// obj_scheduler: five-slot sprite allocator and per-frame object updater.
// Spawns take the lowest free slot; a vsync fall runs a slot-serial update.
module obj_scheduler #(
   parameter logic [10:0] SPAWN_X      = 11'd1023,
   parameter int          ANIM_DIV_LOG = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        pause,
   input  logic        clear,
   input  logic [3:0]  speed,
   input  logic        spawn_req,
   input  logic [1:0]  spawn_type,
   input  logic [9:0]  spawn_vpos,
   output logic        spawn_ack,
   output logic        spawn_drop,
   output logic [25:0] obj1,
   output logic [25:0] obj2,
   output logic [25:0] obj3,
   output logic [25:0] obj4,
   output logic [25:0] obj5,
   output logic [4:0]  obj_valid,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_UPD, S_DONE, S_SPAWN, S_GUARD
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [25:0]             r_slot [5];
   logic [4:0]              r_valid;
   logic [2:0]              r_idx;
   logic [ANIM_DIV_LOG-1:0] r_anim;
   logic                    r_vsync_prev;
   logic                    r_pend;
   logic                    r_ok;
   logic                    r_ack;
   logic                    r_drop;
   logic                    r_done;
   logic                    w_fall;
   logic                    w_evt;
   logic                    w_full;
   logic                    w_retire;
   logic                    w_adv;
   logic [2:0]              w_free;
   logic [25:0]             w_cur;
   logic [25:0]             w_upd;
   logic [10:0]             w_spd;

   assign w_fall   = r_vsync_prev & ~vsync;
   assign w_evt    = w_fall | r_pend;
   assign w_full   = &r_valid;
   assign w_spd    = {7'd0, speed};
   assign w_cur    = r_slot[r_idx];
   assign w_adv    = &r_anim;
   // Retiring before subtracting keeps hpos from ever wrapping.
   assign w_retire = (speed != 4'd0) && (w_cur[20:10] <= w_spd);
   assign w_upd    = {w_cur[25:23] + {2'd0, w_adv}, w_cur[22:21],
                      w_cur[20:10] - w_spd, w_cur[9:0]};

   always_comb begin
      w_free = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (!r_valid[i]) w_free = 3'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_evt && !pause)        w_state_nxt = S_UPD;
            else if (!w_evt && spawn_req) w_state_nxt = S_SPAWN;
         end
         S_UPD:   if (r_idx == 3'd4) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         S_SPAWN: w_state_nxt = S_GUARD;
         S_GUARD: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 5; i++) r_slot[i] <= 26'd0;
         r_valid      <= 5'd0;
         r_idx        <= 3'd0;
         r_anim       <= '0;
         r_vsync_prev <= 1'b0;
         r_pend       <= 1'b0;
         r_ok         <= 1'b0;
         r_ack        <= 1'b0;
         r_drop       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_vsync_prev <= vsync;
         r_ack        <= 1'b0;
         r_drop       <= 1'b0;
         r_done       <= 1'b0;
         if (clear) begin
            for (int i = 0; i < 5; i++) r_slot[i] <= 26'd0;
            r_valid <= 5'd0;
            r_pend  <= 1'b0;
            r_idx   <= 3'd0;
            r_ok    <= 1'b0;
         end else begin
            // IDLE consumes any event; elsewhere one fall is remembered.
            if (r_state == S_IDLE) r_pend <= 1'b0;
            else if (w_fall)       r_pend <= 1'b1;
            unique case (r_state)
               S_IDLE: r_idx <= 3'd0;
               S_UPD: begin
                  if (r_valid[r_idx]) begin
                     if (w_retire) begin
                        r_slot[r_idx]  <= 26'd0;
                        r_valid[r_idx] <= 1'b0;
                     end else begin
                        r_slot[r_idx] <= w_upd;
                     end
                  end
                  r_idx <= r_idx + 3'd1;
               end
               S_DONE: begin
                  r_done <= 1'b1;
                  r_anim <= r_anim + 1'b1;
               end
               S_SPAWN: begin
                  r_ok <= ~w_full;
                  if (!w_full) begin
                     r_slot[w_free]  <= {3'd0, spawn_type, SPAWN_X, spawn_vpos};
                     r_valid[w_free] <= 1'b1;
                  end
               end
               S_GUARD: begin
                  r_ack  <= r_ok;
                  r_drop <= ~r_ok;
               end
               default: ;
            endcase
         end
      end
   end

   assign obj1       = r_slot[0];
   assign obj2       = r_slot[1];
   assign obj3       = r_slot[2];
   assign obj4       = r_slot[3];
   assign obj5       = r_slot[4];
   assign obj_valid  = r_valid;
   assign busy       = (r_state != S_IDLE);
   assign spawn_ack  = r_ack;
   assign spawn_drop = r_drop;
   assign frame_done = r_done;

endmodule

// File: doc/obj_scheduler.md
Name: obj_scheduler

Overview:
- Owns the five sprite object slots (obj1..obj5) consumed by the display block.
- Accepts spawn requests from game logic over a req/ack handshake and allocates the lowest free slot.
- On each frame boundary (vsync falling edge) it runs a sequential per-slot update: scroll left, advance the animation frame, retire off-screen objects.
- Replaces the ad-hoc per-frame object registers in the top level; runs on the 65 MHz pixel clock.

Parameters:
- SPAWN_X, 11'd1023, hpos loaded into a newly spawned object.
- ANIM_DIV_LOG, 3, animation field advances once every 2^ANIM_DIV_LOG updated frames.

Ports:
- clock  in  1  65 MHz pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- vsync  in  1  xvga vsync (active high, synchronous to clock).
- pause  in  1  level; while high, frame updates are skipped entirely.
- clear  in  1  single-cycle pulse; invalidates all slots.
- speed  in  4  pixels scrolled per frame.
- spawn_req  in  1  level; held high until spawn_ack or spawn_drop is seen.
- spawn_type  in  2  object type for the spawn; must be stable while spawn_req is high.
- spawn_vpos  in  10  vertical position for the spawn; must be stable while spawn_req is high.
- spawn_ack  out  1  1-cycle pulse: the spawn was placed.
- spawn_drop  out  1  1-cycle pulse: all slots were full and the spawn was discarded.
- obj1..obj5  out  26 each  {frame[25:23], type[22:21], hpos[20:10], vpos[9:0]}; 26'd0 when the slot is invalid.
- obj_valid  out  5  bit i-1 is set when obj_i is valid.
- busy  out  1  high when the FSM is not in IDLE.
- frame_done  out  1  1-cycle pulse when a frame update completes.

Behaviour:
- Reset (asynchronous, reset_n low) clears all slots, obj_valid, both spawn pulses, busy, frame_done and the animation counter. FSM goes to IDLE. vsync_prev resets to 0.
- vsync falling edge: detected when vsync_prev=1 and vsync=0. An edge detected outside IDLE sets a pending flag; the flag is serviced on the next IDLE cycle. At most one pending edge is stored; further edges are lost.
- FSM states:
  - IDLE:
    - clear has top priority in every state: it zeroes all slots and pending, aborts any spawn or update without pulses, and returns the FSM to IDLE.
    - Otherwise, an edge or pending with pause=0 goes to UPD; pending is cleared.
    - Otherwise, an edge or pending with pause=1 is consumed with no update and pending is cleared.
    - Otherwise, spawn_req=1 goes to SPAWN.
    - Frame update beats spawn when both arrive together; spawn_req stays pending.
  - UPD:
    - Slot index i = 0..4, one slot per cycle, i.e. on edges k+1..k+5 when the edge is sampled at edge k.
    - Valid slot with hpos <= speed and speed != 0: retire (slot zeroed, valid cleared).
    - Other valid slots: hpos <= hpos - speed (11-bit; no underflow is possible because of the retire rule).
    - Frame field increments mod 8 when anim_cnt == all-ones.
    - Invalid slots are unchanged.
    - After slot 4: go to DONE.
  - DONE:
    - frame_done=1 for one cycle.
    - anim_cnt increments (ANIM_DIV_LOG bits, wraps).
    - Go to IDLE.
  - SPAWN:
    - Find the lowest-index invalid slot.
    - If found: write {3'd0, spawn_type, SPAWN_X, spawn_vpos}, set valid, and pulse spawn_ack on the following cycle.
    - If all 5 slots are valid: pulse spawn_drop instead.
    - Then go to GUARD.
  - GUARD:
    - One cycle in which spawn_req is ignored, giving the requester time to deassert.
    - Go to IDLE.
- Latency:
  - spawn_ack/spawn_drop is asserted 2 edges after spawn_req is sampled in IDLE.
  - frame_done is asserted 6 edges after the vsync edge is sampled in IDLE.
- speed=0: no motion and no retirement; the animation frame still advances.
- obj outputs are registered directly from the slot registers; there is no combinational path from inputs.

Test Plan:
- Reset with reset_n low mid-UPD -> all obj=0, obj_valid=0, busy=0 immediately; after release the FSM is IDLE.
- spawn_req, type=2, vpos=300, from empty -> spawn_ack 2 cycles later; obj1={3'd0,2'd2,11'd1023,10'd300}; obj_valid=5'b00001.
- Spawn 6 times with all other inputs idle -> 5 acks filling slots 1..5, then spawn_drop on the 6th; slot contents unchanged.
- obj1 hpos=10, speed=4, three vsync falls -> hpos 6, then 2, then retired (obj1=0, valid bit 0); frame_done pulses 6 cycles after each edge.
- 8 frames with speed=1 and ANIM_DIV_LOG=3 -> frame field goes 0→1 exactly once; with pause=1 over 8 more edges -> no change and no frame_done.
- spawn_req asserted on the same cycle as a vsync fall -> update runs first (frame_done), then spawn_ack; clear pulse during UPD -> all slots zero, no frame_done.
